// File: rtl/pwm_rc_pkg.sv
// pwm_rc_pkg: definitions shared by the RC PWM generator and the RC pulse
// capture path.
//   WORDSIZE               width of width/period values, 1 LSB = 1 us
//   pwm_width_t            width/period value type
//   ADDR_CH1..ADDR_CH6     register addresses of the channel width shadows
//   ADDR_PERIOD            register address of the frame period shadow
//   DEFAULT_PERIOD/WIDTH   values loaded at reset
package pwm_rc_pkg;

    localparam int WORDSIZE = 15;

    typedef logic [WORDSIZE-1:0] pwm_width_t;

    localparam logic [2:0] ADDR_CH1    = 3'd0;
    localparam logic [2:0] ADDR_CH2    = 3'd1;
    localparam logic [2:0] ADDR_CH3    = 3'd2;
    localparam logic [2:0] ADDR_CH4    = 3'd3;
    localparam logic [2:0] ADDR_CH5    = 3'd4;
    localparam logic [2:0] ADDR_CH6    = 3'd5;
    localparam logic [2:0] ADDR_PERIOD = 3'd6;

    localparam pwm_width_t DEFAULT_PERIOD = 15'd20000;
    localparam pwm_width_t DEFAULT_WIDTH  = 15'd1500;

endpackage

// File: rtl/pwm_gen_ch.sv
// pwm_gen_ch: one PWM channel.
//   clk, rst        clock, asynchronous active-high reset
//   en              output enable (low forces output low next clk)
//   tick            pwm_clk strobe qualified by en
//   boundary        this tick starts a new frame
//   fs_load         at this boundary load DEFAULT_WIDTH instead of the shadow
//   cnt_next        frame counter value after this tick
//   wr_sel          write strobe for this channel's width shadow
//   wr_data         write data (us)
//   pwm_out         registered PWM output
module pwm_gen_ch
    import pwm_rc_pkg::*;
#(
    parameter pwm_width_t DEFAULT_WIDTH = pwm_rc_pkg::DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic       boundary,
    input  logic       fs_load,
    input  pwm_width_t cnt_next,
    input  logic       wr_sel,
    input  pwm_width_t wr_data,
    output logic       pwm_out
);

    pwm_width_t shadow_q, shadow_d;
    pwm_width_t act_q, act_d;
    logic       out_q, out_d;
    pwm_width_t load_val;

    always_comb begin
        shadow_d = shadow_q;
        act_d    = act_q;
        out_d    = out_q;
        load_val = fs_load ? DEFAULT_WIDTH : shadow_q;

        // The boundary reads shadow_q, so a write in the same clk only
        // becomes visible at the following boundary.
        if (wr_sel) shadow_d = wr_data;
        if (boundary) act_d = load_val;

        if (!en)
            out_d = 1'b0;
        else if (boundary)
            out_d = (load_val != '0);
        else if (tick)
            out_d = (cnt_next < act_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= DEFAULT_WIDTH;
            act_q    <= DEFAULT_WIDTH;
            out_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            act_q    <= act_d;
            out_q    <= out_d;
        end
    end

    assign pwm_out = out_q;

endmodule

// File: rtl/pwm_gen_rc.sv
// pwm_gen_rc: frame-synchronous multi-channel servo/ESC PWM generator.
// Widths and period are written into shadow registers and applied only at
// frame boundaries.
//   clk, rst        clock, asynchronous active-high reset
//   pwm_clk         1 MHz tick, one clk wide
//   en              output enable; low forces outputs low and restarts frame
//   wr_en/addr/data register write port (0..5 channel widths, 6 period)
//   pwm_out         PWM outputs, bit 0 = channel 1
//   frame_start     one-clk pulse at each frame start
//   failsafe_act    failsafe active flag
// Optional feature macro: PWM_FAILSAFE_EN (frame-count failsafe).
module pwm_gen_rc
    import pwm_rc_pkg::*;
#(
    parameter int         NUM_CH          = 6,
    parameter pwm_width_t DEFAULT_PERIOD  = pwm_rc_pkg::DEFAULT_PERIOD,
    parameter pwm_width_t DEFAULT_WIDTH   = pwm_rc_pkg::DEFAULT_WIDTH,
    parameter int         FAILSAFE_FRAMES = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_clk,
    input  logic              en,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  pwm_width_t        wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_start,
    output logic              failsafe_act
);

    pwm_width_t cnt_q, cnt_d;
    pwm_width_t period_sh_q, period_sh_d;
    pwm_width_t period_act_q, period_act_d;
    logic       start_q, start_d;
    logic       frame_start_q, frame_start_d;

    logic              tick;
    logic              boundary;
    logic              ch_wr;
    logic              fs_load;
    pwm_width_t        cnt_next;
    logic [NUM_CH-1:0] wr_sel;

    assign tick     = pwm_clk & en;
    // period_act_q >= 2 always, so the compare never sees an underflow.
    assign boundary = tick & (start_q | (cnt_q == period_act_q - pwm_width_t'(1)));
    assign cnt_next = boundary ? '0 : cnt_q + pwm_width_t'(1);
    assign ch_wr    = wr_en & (wr_addr <= ADDR_CH6);

    always_comb begin
        cnt_d         = cnt_q;
        start_d       = start_q;
        period_sh_d   = period_sh_q;
        period_act_d  = period_act_q;
        frame_start_d = boundary;

        if (!en) begin
            cnt_d   = '0;
            start_d = 1'b1;
        end else if (tick) begin
            cnt_d = cnt_next;
            if (boundary) start_d = 1'b0;
        end

        if (boundary) period_act_d = period_sh_q;
        // Periods below 2 would leave no room for a counting frame.
        if (wr_en && wr_addr == ADDR_PERIOD && wr_data >= pwm_width_t'(2))
            period_sh_d = wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            start_q       <= 1'b1;
            period_sh_q   <= DEFAULT_PERIOD;
            period_act_q  <= DEFAULT_PERIOD;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            start_q       <= start_d;
            period_sh_q   <= period_sh_d;
            period_act_q  <= period_act_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

`ifdef PWM_FAILSAFE_EN
    localparam int FS_W = $clog2(FAILSAFE_FRAMES + 1);

    logic [FS_W-1:0] fs_cnt_q, fs_cnt_d;
    logic            fs_act_q, fs_act_d;
    logic            fs_hit;

    // A channel write in the boundary clk wins: its shadow is used next
    // frame and the counter restarts.
    assign fs_hit = boundary & ~ch_wr & (int'(fs_cnt_q) >= FAILSAFE_FRAMES - 1);

    always_comb begin
        fs_cnt_d = fs_cnt_q;
        fs_act_d = fs_act_q;
        if (ch_wr) begin
            fs_cnt_d = '0;
            fs_act_d = 1'b0;
        end else if (boundary) begin
            if (int'(fs_cnt_q) < FAILSAFE_FRAMES) fs_cnt_d = fs_cnt_q + 1'b1;
            if (fs_hit) fs_act_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_cnt_q <= '0;
            fs_act_q <= 1'b0;
        end else begin
            fs_cnt_q <= fs_cnt_d;
            fs_act_q <= fs_act_d;
        end
    end

    assign fs_load      = fs_hit;
    assign failsafe_act = fs_act_q;
`else
    assign fs_load      = 1'b0;
    assign failsafe_act = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = wr_en & (wr_addr == 3'(i));

        pwm_gen_ch #(
            .DEFAULT_WIDTH(DEFAULT_WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .tick    (tick),
            .boundary(boundary),
            .fs_load (fs_load),
            .cnt_next(cnt_next),
            .wr_sel  (wr_sel[i]),
            .wr_data (wr_data),
            .pwm_out (pwm_out[i])
        );
    end

endmodule
